// File: rtl/my_cic_decimator.sv
// N-stage CIC decimator, differential delay 1: gated integrators, phase counter,
// wrap-token pipeline that snapshots the last integrator, comb chain on the strobe.
module my_cic_decimator #(
    parameter int unsigned IN_WIDTH         = 12,
    parameter int unsigned OUT_WIDTH        = 10,
    parameter int unsigned DECIMATION       = 8,
    parameter int unsigned DECIMATION_WIDTH = 3,
    parameter int unsigned STAGES           = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    input  logic                        in_valid,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_valid
);

    localparam int unsigned FULL  = IN_WIDTH + STAGES * DECIMATION_WIDTH;
    localparam int unsigned SHIFT = FULL - OUT_WIDTH;

    logic signed [FULL-1:0]             in_ext;
    logic signed [FULL-1:0]             integ_q [STAGES];
    logic signed [FULL-1:0]             integ_d [STAGES];
    logic [DECIMATION_WIDTH-1:0]        phase_q, phase_d;
    logic                               wrap_c;
    logic                               tok_q   [STAGES+1];
    logic signed [FULL-1:0]             snap_q  [STAGES+1];
    logic signed [FULL-1:0]             dly_q   [STAGES];
    logic signed [FULL-1:0]             dly_d   [STAGES];
    logic signed [FULL-1:0]             comb_acc;
    logic signed [OUT_WIDTH-1:0]        out_d;
    logic signed [OUT_WIDTH-1:0]        out_data_q;
    logic                               out_valid_q;
    logic                               strobe;

    assign in_ext    = {{(FULL-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
    assign strobe    = tok_q[STAGES];
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    // Integrator cascade and phase counter, both frozen while in_valid is low
    always_comb begin
        integ_d = integ_q;
        phase_d = phase_q;
        wrap_c  = 1'b0;
        if (in_valid) begin
            integ_d[0] = integ_q[0] + in_ext;
            for (int k = 1; k < STAGES; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
            wrap_c  = (phase_q == DECIMATION_WIDTH'(DECIMATION - 1));
            phase_d = wrap_c ? '0 : phase_q + DECIMATION_WIDTH'(1);
        end
    end

    // Comb chain evaluated on the snapshot that reaches the end of the token pipeline
    always_comb begin
        comb_acc = snap_q[STAGES];
        for (int k = 0; k < STAGES; k++) begin
            dly_d[k] = comb_acc;
            comb_acc = comb_acc - dly_q[k];
        end
        out_d = OUT_WIDTH'(comb_acc >>> SHIFT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
            for (int j = 0; j <= STAGES; j++) begin
                tok_q[j]  <= 1'b0;
                snap_q[j] <= '0;
            end
        end else begin
            integ_q   <= integ_d;
            phase_q   <= phase_d;
            tok_q[0]  <= wrap_c;
            if (wrap_c) begin
                snap_q[0] <= integ_d[STAGES-1];
            end
            // Snapshot travels with its token so back-to-back input cannot corrupt it
            for (int j = 1; j <= STAGES; j++) begin
                tok_q[j] <= tok_q[j-1];
                if (tok_q[j-1]) begin
                    snap_q[j] <= snap_q[j-1];
                end
            end
            out_valid_q <= strobe;
            if (strobe) begin
                dly_q      <= dly_d;
                out_data_q <= out_d;
            end
        end
    end

endmodule

// File: tb/tb_my_cic_decimator.sv
// Directed bench for my_cic_decimator: sample-domain reference model plus
// hand-computed steady-state values, checked with immediate assertions.
module tb_my_cic_decimator;

    localparam int IW   = 12;
    localparam int OW   = 10;
    localparam int R    = 8;
    localparam int N    = 3;
    localparam int FULL = 21;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b1;
    logic                  in_valid = 1'b0;
    logic signed [IW-1:0]  in_data = '0;
    logic signed [OW-1:0]  out_data;
    logic                  out_valid;

    always #5 clk = ~clk;

    my_cic_decimator #(
        .IN_WIDTH(12), .OUT_WIDTH(10), .DECIMATION(8), .DECIMATION_WIDTH(3), .STAGES(3)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .out_data (out_data),
        .out_valid(out_valid)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic signed [FULL-1:0] mi [N];
    logic signed [FULL-1:0] md [N];
    int                     mph;
    int                     exp_cyc_q [$];
    logic signed [OW-1:0]   exp_dat_q [$];
    logic signed [OW-1:0]   last_out;
    int                     vcount;
    int                     dut_cnt;
    logic                   hand_en = 1'b0;
    logic signed [OW-1:0]   hand_val = '0;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic check_dat(input string tag, input logic signed [OW-1:0] obs,
                             input logic signed [OW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mi[k] = '0;
            md[k] = '0;
        end
        mph = 0;
        exp_cyc_q.delete();
        exp_dat_q.delete();
        last_out = '0;
        vcount   = 0;
        dut_cnt  = 0;
    endtask

    // One accepted sample through the reference CIC; a finished frame is queued
    // with the cycle on which its output must appear (wrap edge + N + 1).
    task automatic model_sample(input int x);
        logic signed [FULL-1:0] ni [N];
        logic signed [FULL-1:0] c, t;
        ni[0] = mi[0] + FULL'(x);
        for (int k = 1; k < N; k++) ni[k] = mi[k] + mi[k-1];
        for (int k = 0; k < N; k++) mi[k] = ni[k];
        mph++;
        if (mph == R) begin
            mph = 0;
            c = mi[N-1];
            for (int k = 0; k < N; k++) begin
                t     = c - md[k];
                md[k] = c;
                c     = t;
            end
            exp_cyc_q.push_back(cyc + N + 1);
            exp_dat_q.push_back(OW'(c >>> (FULL - OW)));
        end
    endtask

    task automatic step(input logic v, input int x);
        logic                 exp_v;
        logic signed [OW-1:0] d;
        in_valid = v;
        in_data  = IW'(x);
        @(posedge clk);
        cyc++;
        if (v) model_sample(x);
        #1;
        exp_v = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
        if (out_valid) dut_cnt++;
        check_bit("out_valid", out_valid, exp_v);
        if (exp_v) begin
            void'(exp_cyc_q.pop_front());
            d = exp_dat_q.pop_front();
            last_out = d;
            vcount++;
            check_dat("out_data", out_data, d);
            if (hand_en && vcount >= 4) check_dat("out_data_steady", out_data, hand_val);
        end else begin
            check_dat("out_hold", out_data, last_out);
        end
    endtask

    // Called just after a rising edge; reset lands mid-cycle to exercise the async path
    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        check_bit("rst_valid_async", out_valid, 1'b0);
        check_dat("rst_data_async", out_data, '0);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        check_bit("rst_valid_held", out_valid, 1'b0);
        check_dat("rst_data_held", out_data, '0);
        reset_n = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Constant 400: 50 frames over 400 cycles, steady output 100, integrators wrap many times
        hand_en  = 1'b1;
        hand_val = 10'sd100;
        for (int i = 0; i < 400; i++) step(1'b1, 400);
        for (int i = 0; i < N + 1; i++) step(1'b0, 0);
        check_int("valid_count_400", dut_cnt, 50);

        // Negative full scale
        do_reset();
        hand_val = -10'sd512;
        for (int i = 0; i < 80; i++) step(1'b1, -2048);
        for (int i = 0; i < N + 1; i++) step(1'b0, 0);
        check_int("valid_count_neg", dut_cnt, 10);

        // Positive full scale
        do_reset();
        hand_val = 10'sd511;
        for (int i = 0; i < 80; i++) step(1'b1, 2047);
        for (int i = 0; i < N + 1; i++) step(1'b0, 0);

        // Reset after 5 of 8 samples discards the partial frame
        hand_en = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 300);
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 50);
        for (int i = 0; i < N + 2; i++) step(1'b0, 0);
        check_int("no_valid_before_8th", dut_cnt, 0);
        step(1'b1, 50);
        for (int i = 0; i < N + 1; i++) step(1'b0, 0);
        check_int("valid_after_8th", dut_cnt, 1);

        // Gapped constant 400 must give the same frames as the gap-free run
        do_reset();
        hand_en  = 1'b1;
        hand_val = 10'sd100;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 400);
            repeat ($urandom_range(0, 5)) step(1'b0, int'($urandom_range(0, 4095)) - 2048);
        end
        for (int i = 0; i < N + 1; i++) step(1'b0, 0);
        check_int("valid_count_gaps", dut_cnt, 8);

        // Random data with random gaps against the reference model
        do_reset();
        hand_en = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, int'($urandom_range(0, 4095)) - 2048);
            step(1'b1, int'($urandom_range(0, 4095)) - 2048);
        end
        for (int i = 0; i < N + 1; i++) step(1'b0, 0);
        check_int("valid_count_random", dut_cnt, 1250);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/my_cic_decimator.md
MY_CIC_DECIMATOR -- requirements
Module: my_cic_decimator

Interface
REQ-001 Parameter IN_WIDTH, default 12: signed input sample width.
REQ-002 Parameter OUT_WIDTH, default 10: signed output width; feeds the block-average stage data input.
REQ-003 Parameter DECIMATION, default 8: rate-change factor R, a power of two, at least 2.
REQ-004 Parameter DECIMATION_WIDTH, default 3: log2(DECIMATION).
REQ-005 Parameter STAGES, default 3: CIC order N, range 1..5; differential delay fixed at 1.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-008 Port in_data, input, IN_WIDTH bits: signed two's-complement sample, qualified by in_valid.
REQ-009 Port in_valid, input, 1 bit: one-cycle strobe; arbitrary gaps allowed, back-to-back allowed.
REQ-010 Port out_data, output, OUT_WIDTH bits: signed decimated sample, held between updates.
REQ-011 Port out_valid, output, 1 bit: one-cycle strobe marking a new out_data.

Function
REQ-012 The block SHALL use internal width FULL = IN_WIDTH + STAGES*DECIMATION_WIDTH for all integrator, comb and delay registers (default 21).
REQ-013 The block SHALL sign-extend in_data to FULL bits before the first integrator.
REQ-014 The block SHALL, on each cycle with in_valid=1, update all STAGES integrators in cascade: I1 += x, Ik += I(k-1) (registered values, one pipeline register per stage).
REQ-015 Integrators SHALL NOT change when in_valid=0.
REQ-016 Integrator arithmetic SHALL be modular two's complement; wrap-around is legal and SHALL NOT be saturated or flagged.
REQ-017 A DECIMATION_WIDTH-bit phase counter SHALL increment on each in_valid and wrap from DECIMATION-1 to 0.
REQ-018 On the in_valid that makes the counter wrap, a decimation strobe SHALL be raised for exactly one cycle.
REQ-019 On the strobe, the combs SHALL run as a chain: Ck = C(k-1) - D(k-1), then Dk <= C(k-1); C0 is the last integrator output.
REQ-020 Comb state SHALL change only on strobe cycles.
REQ-021 out_data SHALL be bits [FULL-1 : FULL-OUT_WIDTH] of the final comb output (truncation, no rounding).
REQ-022 out_valid SHALL be high exactly one cycle, 1 cycle after the strobe.
REQ-023 out_data SHALL update in that same cycle and hold until the next out_valid.
REQ-024 Total latency from the wrapping in_valid edge to the out_valid edge SHALL be STAGES+1 cycles (integrator pipeline plus output register).
REQ-025 Integrator pipeline registers SHALL advance only on in_valid; the strobe SHALL be aligned to the last integrator's update.
REQ-026 out_valid SHALL occur exactly once per DECIMATION accepted in_valid pulses, independent of gap pattern.
REQ-027 DC gain SHALL be R^N / 2^(FULL-OUT_WIDTH); with defaults, steady-state out = floor(x/4).
REQ-028 With defaults, full-scale input SHALL map to -512..511 with no overflow.

Reset
REQ-029 Asserting reset_n low SHALL asynchronously clear the integrators, pipeline registers, combs, delays, phase counter, strobe, out_data (to 0) and out_valid (to 0).
REQ-030 Reset asserted mid-frame SHALL discard the partial frame.
REQ-031 After reset release, the first out_valid SHALL follow exactly DECIMATION accepted in_valid pulses.
REQ-032 After reset release, the block SHALL act on the first rising clk edge with reset_n=1.

Verification
REQ-033 Defaults, in_data=400 continuous every cycle: out_valid every 8 cycles; out_data=100 from the 4th out_valid on.
REQ-034 Defaults, in_data=-2048 continuous: out_data=-512 from the 4th out_valid on; in_data=2047: out_data=511.
REQ-035 Defaults, in_valid gaps of random length (0..5 cycles): exactly 1 out_valid per 8 strobes; the out_data sequence matches the gap-free run.
REQ-036 Run for 2^21 input samples so the integrators wrap: out_data stays 100 for in_data=400 with no glitch at wrap.
REQ-037 Assert reset_n low after 5 of 8 samples, release, feed 8 samples: out_valid only after the 8th; out_data=0 and out_valid=0 during reset.
REQ-038 Bit-exact comparison against a reference CIC model over 10,000 random inputs; any mismatch fails.
